// File: rtl/alu_seq_exec_if.sv
// Request/response bundle for alu_seq_exec: op + operands in, registered result + zero out.
// The master drives the request side and accepts results; the slave is the execute unit.
interface alu_seq_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, alu_ctl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execute unit: logic/arith in one cycle, shifts 1 bit/cycle (ALU_SEQ_BARREL_EN: barrel, all ops 1 cycle).
// Latency: out_valid 1 cycle after accept, or max(n,1) cycles for a shift by n in the iterative build.
// Backpressure: in_ready only in IDLE; result/zero held in DONE until out_valid & out_ready.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_exec_if.slave  bus
);
    localparam int SH = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;

`ifdef ALU_SEQ_BARREL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             res_we;

    function automatic logic [WIDTH-1:0] alu_eval(input logic [3:0]       ctl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (ctl)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_SEQ_BARREL_EN
            OP_SLL:  r = a << b[SH-1:0];
            OP_SRL:  r = a >> b[SH-1:0];
            OP_SRA:  r = $signed(a) >>> b[SH-1:0];
`else
            // Only reached for a zero shift amount; real shifts go through SHIFT.
            OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

`ifndef ALU_SEQ_BARREL_EN
    localparam logic [SH-1:0] ONE = SH'(1);

    logic [WIDTH-1:0] work_q, work_d;
    logic [SH-1:0]    cnt_q, cnt_d;
    logic [1:0]       kind_q, kind_d;
    logic [SH-1:0]    shamt;
    logic             is_shift;
    logic [WIDTH-1:0] first_step, next_step;

    // kind: 00 SLL, 01 SRL, 1x SRA (low bits of the shift opcodes)
    function automatic logic [WIDTH-1:0] step1(input logic [1:0] kind, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (kind)
            2'b00:   r = {v[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, v[WIDTH-1:1]};
            default: r = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign shamt      = bus.op_b[SH-1:0];
    assign is_shift   = (bus.alu_ctl == OP_SLL) || (bus.alu_ctl == OP_SRL) || (bus.alu_ctl == OP_SRA);
    assign first_step = step1(bus.alu_ctl[1:0], bus.op_a);
    assign next_step  = step1(kind_q, work_q);
`endif

    always_comb begin
        state_nxt = state;
        res_we    = 1'b0;
        res_d     = '0;
`ifndef ALU_SEQ_BARREL_EN
        work_d    = work_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
`ifndef ALU_SEQ_BARREL_EN
                    // The accept edge already performs the first step, so a shift by n costs n cycles.
                    if (is_shift && (shamt != '0)) begin
                        if (shamt == ONE) begin
                            res_we    = 1'b1;
                            res_d     = first_step;
                            state_nxt = DONE;
                        end else begin
                            work_d    = first_step;
                            cnt_d     = shamt - ONE;
                            kind_d    = bus.alu_ctl[1:0];
                            state_nxt = SHIFT;
                        end
                    end else
`endif
                    begin
                        res_we    = 1'b1;
                        res_d     = alu_eval(bus.alu_ctl, bus.op_a, bus.op_b);
                        state_nxt = DONE;
                    end
                end
            end
`ifndef ALU_SEQ_BARREL_EN
            SHIFT: begin
                work_d = next_step;
                cnt_d  = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    res_we    = 1'b1;
                    res_d     = next_step;
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            zero_q <= 1'b0;
`ifndef ALU_SEQ_BARREL_EN
            work_q <= '0;
            cnt_q  <= '0;
            kind_q <= '0;
`endif
        end else begin
            if (res_we) begin
                res_q  <= res_d;
                zero_q <= zero_d;
            end
`ifndef ALU_SEQ_BARREL_EN
            work_q <= work_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: transaction-level model checked every cycle plus hand-computed vectors.
module tb_alu_seq_exec;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_exec_if #(.WIDTH(W)) bus ();
    alu_seq_exec #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (ctl)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a ^ b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: return (a < b) ? 32'd1 : 32'd0;
            4'b1000: return a << n;
            4'b1001: return a >> n;
            4'b1010: return $signed(a) >>> n;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int build_lat(input int iter_lat);
        int l;
        l = iter_lat;
`ifdef ALU_SEQ_BARREL_EN
        l = 1;
`endif
        return l;
    endfunction

    function automatic int ref_lat(input logic [3:0] ctl, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        if ((ctl == 4'b1000 || ctl == 4'b1001 || ctl == 4'b1010) && n != 0) return build_lat(n);
        return 1;
    endfunction

    // Transaction-level model: one op in flight, result visible after its latency, cleared by handshake or reset.
    bit          m_known = 0;
    bit          m_inflight = 0;
    bit          m_vout = 0;
    logic [31:0] m_res = '0;
    int          m_wait = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_known    = 1;
            m_inflight = 0;
            m_vout     = 0;
            m_wait     = 0;
        end else if (m_known) begin
            if (m_vout && bus.out_ready) begin
                m_vout     = 0;
                m_inflight = 0;
            end else if (!m_inflight && bus.in_valid) begin
                m_res      = ref_op(bus.alu_ctl, bus.op_a, bus.op_b);
                m_inflight = 1;
                m_wait     = ref_lat(bus.alu_ctl, bus.op_b) - 1;
                if (m_wait == 0) m_vout = 1;
            end else if (m_inflight && !m_vout) begin
                m_wait--;
                if (m_wait == 0) m_vout = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("out_valid", bus.out_valid, m_vout);
            chk("in_ready", bus.in_ready, !rst && !m_inflight);
            chk("busy", bus.busy, m_inflight);
            if (m_vout) begin
                chk("result", bus.result, m_res);
                chk("zero", bus.zero, m_res == 32'd0);
            end
        end
    end

    task automatic run_op(input string nm, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int iter_lat, input int hold);
        int lat;
        bit seen;
        chk({nm, " model"}, ref_op(ctl, a, b), exp_res);
        @(posedge clk); #2;
        bus.in_valid  = 1'b1;
        bus.alu_ctl   = ctl;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.out_ready = (hold == 0);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        bus.alu_ctl  = 4'b0010;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 80 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
                lat  = i;
            end
        end
        chk({nm, " latency"}, lat, build_lat(iter_lat));
        if (seen) begin
            chk({nm, " result"}, bus.result, exp_res);
            chk({nm, " zero"}, bus.zero, exp_res == 32'd0);
            if (hold > 0) begin
                repeat (hold) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk({nm, " held valid"}, bus.out_valid, 1'b1);
                    chk({nm, " held result"}, bus.result, exp_res);
                    chk({nm, " held in_ready"}, bus.in_ready, 1'b0);
                end
                @(posedge clk); #2;
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            chk({nm, " idle in_ready"}, bus.in_ready, 1'b1);
            chk({nm, " idle out_valid"}, bus.out_valid, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int stale;
        bus.in_valid  = 1'b0;
        bus.alu_ctl   = 4'b0000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset result", bus.result, 32'd0);
        chk("reset zero", bus.zero, 1'b0);
        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset in_ready", bus.in_ready, 1'b1);

        run_op("add wrap",  4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1,  0);
        run_op("sub zero",  4'b0110, 32'd5,         32'd5,         32'h0,         1,  0);
        run_op("slt",       4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1,  0);
        run_op("sltu",      4'b1011, 32'hFFFF_FFFF, 32'h1,         32'h0,         1,  0);
        run_op("and",       4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1,  0);
        run_op("or",        4'b0001, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1,  0);
        run_op("sra 4",     4'b1010, 32'h8000_0000, 32'h4,         32'hF800_0000, 4,  0);
        run_op("sra hi b",  4'b1010, 32'h8000_00F0, 32'hFFFF_FFE4, 32'hF800_000F, 4,  0);
        run_op("sll 0",     4'b1000, 32'h1,         32'h0,         32'h1,         1,  0);
        run_op("sll 1",     4'b1000, 32'h3,         32'h21,        32'h6,         1,  0);
        run_op("srl 31",    4'b1001, 32'h8000_0000, 32'd31,        32'h1,         31, 0);
        run_op("sll 31 z",  4'b1000, 32'h2,         32'd31,        32'h0,         31, 0);
        run_op("xor bp",    4'b0011, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1,  5);
        run_op("sra bp",    4'b1010, 32'h4000_0000, 32'd3,         32'h0800_0000, 3,  2);
        run_op("unknown",   4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         1,  0);

        // Reset in the middle of an op: nothing may come out afterwards.
        @(posedge clk); #2;
        bus.in_valid  = 1'b1;
        bus.alu_ctl   = 4'b1000;
        bus.op_a      = 32'h1;
        bus.op_b      = 32'd20;
        bus.out_ready = 1'b0;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst cycle in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid rst out_valid", bus.out_valid, 1'b0);
        chk("mid rst result", bus.result, 32'h0);
        chk("mid rst zero", bus.zero, 1'b0);
        chk("mid rst busy", bus.busy, 1'b0);
        chk("mid rst in_ready", bus.in_ready, 1'b1);
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("no stale output", stale, 0);

        // Reset together with in_valid: the op must not be accepted.
        @(posedge clk); #2;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_ctl  = 4'b0010;
        bus.op_a     = 32'd7;
        bus.op_b     = 32'd8;
        @(posedge clk); #2;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst+valid busy", bus.busy, 1'b0);
        chk("rst+valid out_valid", bus.out_valid, 1'b0);

        run_op("after rst", 4'b0010, 32'd7, 32'd8, 32'd15, 1, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
